shift_rows_pipe: RTL and testbench
==================================

Name: shift_rows_pipe

Overview:
- Parametrised, pipelined ShiftRows/InvShiftRows unit for the Rijndael datapath.
- Supports block widths of 4, 6 and 8 columns (NB).
- Mode (forward/inverse) is selectable per transfer; a sideband tag travels with each block.
- Sits between SubBytes and MixColumns in the round pipeline, with valid/ready handshakes on both sides.

Parameters:
- NB, 4, number of 32-bit state columns; legal values 4, 6, 8; state width W = 32*NB.
- TAG_W, 4, width of the sideband tag carried alongside each block.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  unit can accept a block this cycle.
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows.
- in_state  in  W  input state; byte k = column k/4, row k%4; byte 0 at bits [W-1:W-8].
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output block valid.
- out_ready  in  1  downstream accepts.
- out_state  out  W  shifted state, same byte layout as in_state.
- out_tag  out  TAG_W  tag of the block on out_state.
- busy  out  1  any block held inside the unit.

Behaviour:
- Shift offsets C1..C3 for rows 1..3:
  - NB=4: 1,2,3.
  - NB=6: 1,2,3.
  - NB=8: 1,3,4.
  - Row 0 is never shifted.
- Forward: out(r,c) = in(r, (c + Cr) mod NB).
- Inverse: out(r,c) = in(r, (c - Cr + NB) mod NB).
- Mode is sampled with the block on handshake; it is never a global mode.
- Transfer occurs when valid && ready on the same edge.
- out_valid, out_state and out_tag are registered. Latency is 1 cycle from input handshake to out_valid.
- Throughput is 1 block/cycle while out_ready is held high.
- in_ready = !out_valid || out_ready (combinational path from out_ready).
- Backpressure: while out_valid && !out_ready, out_state and out_tag hold stable.
- Simultaneous output drain and input accept: the new block replaces the old one on the same edge, with no bubble.
- Reset (asynchronous, any time, including mid-transfer): out_valid=0, out_state=0, out_tag=0, busy=0.
  - In-flight data is discarded.
  - in_ready is 1 in the first cycle after reset deasserts.
- busy = out_valid (base build).
- Illegal NB (not 4/6/8) is an elaboration-time fatal error.
- No data transforms apart from byte permutation; the tag is never modified.

Optional Feature:
- Macro: SHIFT_ROWS_SKID_EN.
- Defined:
  - A 1-entry skid buffer is added.
  - in_ready becomes a pure register output (no combinational path from out_ready); in_ready = !skid_valid.
  - When a block arrives while the output is stalled, it is captured already permuted into the skid register.
  - When out_ready next goes high, the skid contents move to the output register.
  - Capacity is 2 blocks; latency is still 1 cycle when unstalled.
  - busy = out_valid || skid_valid.
  - The skid register resets to empty.
- Undefined: the base single-register behaviour above.

Decomposition:
- Package aes_pkg:
  - Shift offset lookup function shift_ofs(nb, row).
  - Byte index helper byte_idx(col, row, nb).
  - Legal-NB constants.
- Sub-module shift_rows_perm: purely combinational permutation (NB parameter, inv input).
  - Instantiated once in the base build.
  - Instantiated once more, or reused on the skid path, when SHIFT_ROWS_SKID_EN is defined.

Test Plan:
- NB=4, forward, in_state=d42711aee0bf98f1b8b45de51e415230, tag=5, out_ready=1 -> next cycle out_valid=1, out_state=d4bf5d30e0b452aeb84111f11e2798e5, out_tag=5.
- NB=4, inverse, in_state=d4bf5d30e0b452aeb84111f11e2798e5 -> out_state=d42711aee0bf98f1b8b45de51e415230.
- NB=8, forward, in_state bytes 00..1f ascending -> first output column = 00 05 0e 13; inverse of that result returns the original bytes.
- Back-to-back 16 blocks with alternating in_inv and out_ready=1 -> 16 outputs on consecutive cycles, in order, correct per-block mode, tags 0..15.
- out_ready held 0 for 5 cycles with a block pending -> out_state stable, in_ready=0 (base) or accepts exactly one more block (SKID_EN); both blocks emerge in order once out_ready=1.
- rst_n pulsed low mid-stream while out_valid=1 -> out_valid drops immediately (asynchronous), out_state=0, busy=0; the first post-reset block is processed correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared Rijndael helpers: ShiftRows offsets, state byte addressing, legal NB values.
package aes_pkg;

  localparam int NB_128 = 4;
  localparam int NB_192 = 6;
  localparam int NB_256 = 8;

  function automatic bit nb_is_legal(input int nb);
    return (nb == NB_128) || (nb == NB_192) || (nb == NB_256);
  endfunction

  // Row 0 never moves; the 256-bit block uses the wider 1/3/4 spread.
  function automatic int shift_ofs(input int nb, input int row);
    if (row == 0) return 0;
    if (nb == NB_256) return (row == 1) ? 1 : (row == 2) ? 3 : 4;
    return row;
  endfunction

  function automatic int byte_idx(input int col, input int row, input int nb);
    return 4 * (col % nb) + row;
  endfunction

  // Byte 0 sits in the most significant byte of the state vector.
  function automatic int byte_lsb(input int idx, input int nb);
    return 8 * (4 * nb - 1 - idx);
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] state_i,
  input  logic             inv_i,
  output logic [32*NB-1:0] state_o
);

  logic [32*NB-1:0] fwd_state;
  logic [32*NB-1:0] inv_state;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int OFS   = shift_ofs(NB, r);
      localparam int SRC_F = (c + OFS) % NB;
      localparam int SRC_I = (c - OFS + NB) % NB;
      localparam int DST   = byte_lsb(byte_idx(c, r, NB), NB);

      assign fwd_state[DST +: 8] = state_i[byte_lsb(byte_idx(SRC_F, r, NB), NB) +: 8];
      assign inv_state[DST +: 8] = state_i[byte_lsb(byte_idx(SRC_I, r, NB), NB) +: 8];
    end
  end

  assign state_o = inv_i ? inv_state : fwd_state;

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows stage with valid/ready handshakes and per-block mode + tag.
// Define SHIFT_ROWS_SKID_EN to add a 1-entry skid buffer and fully registered in_ready.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [32*NB-1:0]   in_state,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_state,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int W = 32 * NB;

  if (!nb_is_legal(NB)) begin : g_bad_nb
    $fatal(1, "shift_rows_pipe: NB=%0d is not one of 4, 6, 8", NB);
  end

  logic [W-1:0]     perm_state;
  logic             accept;
  logic             out_free;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_state_q, out_state_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;

  shift_rows_perm #(.NB(NB)) u_perm (
    .state_i (in_state),
    .inv_i   (in_inv),
    .state_o (perm_state)
  );

  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

`ifdef SHIFT_ROWS_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [W-1:0]     skid_state_q, skid_state_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

  assign in_ready = !skid_valid_q;
  assign busy     = out_valid_q || skid_valid_q;

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_state_d  = out_state_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_state_d = skid_state_q;
    skid_tag_d   = skid_tag_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_state_d  = skid_state_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_state_d = perm_state;
          out_tag_d   = in_tag;
        end
      end
    end else if (accept) begin
      // Output stalled: park the block, already permuted, until the output frees up.
      skid_valid_d = 1'b1;
      skid_state_d = perm_state;
      skid_tag_d   = in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_state_q <= '0;
      skid_tag_q   <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_state_q <= skid_state_d;
      skid_tag_q   <= skid_tag_d;
    end
  end
`else
  assign in_ready = out_free;
  assign busy     = out_valid_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_state_d = out_state_q;
    out_tag_d   = out_tag_q;
    if (out_free) begin
      out_valid_d = accept;
      if (accept) begin
        out_state_d = perm_state;
        out_tag_d   = in_tag;
      end
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe: NB=4 instance for flow control, NB=8 for offsets.
`timescale 1ns/1ps
module tb_shift_rows_pipe;

`ifdef SHIFT_ROWS_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         v4, r4, inv4, ov4, ordy4, busy4;
  logic [127:0] st4, os4;
  logic [3:0]   tg4, ot4;

  logic         v8, r8, inv8, ov8, ordy8, busy8;
  logic [255:0] st8, os8;
  logic [3:0]   tg8, ot8;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v4), .in_ready(r4), .in_inv(inv4), .in_state(st4), .in_tag(tg4),
    .out_valid(ov4), .out_ready(ordy4), .out_state(os4), .out_tag(ot4), .busy(busy4)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(r8), .in_inv(inv8), .in_state(st8), .in_tag(tg8),
    .out_valid(ov8), .out_ready(ordy8), .out_state(os8), .out_tag(ot8), .busy(busy8)
  );

  typedef struct {
    logic [255:0] st;
    logic [3:0]   tag;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t m4, m8;
  int   pop_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ShiftRows written directly from the (row, column) definition.
  function automatic logic [255:0] ref_shift(input logic [255:0] s, input int nb, input bit inv);
    int ofs[4];
    logic [255:0] o;
    int src, w;
    o = '0;
    w = 32 * nb;
    if (nb == 8) ofs = '{0, 1, 3, 4};
    else         ofs = '{0, 1, 2, 3};
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - ofs[r] + nb) % nb : (c + ofs[r]) % nb;
        o[w-1-8*(4*c+r) -: 8] = s[w-1-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  always @(negedge clk) begin
    if (rst_n && ov4 && ordy4) begin
      if (q4.size() == 0) check("unexpected_out4", 1, 0);
      else begin
        m4 = q4.pop_front();
        check("sb_state4", os4, m4.st);
        check("sb_tag4", ot4, m4.tag);
        pop_cyc.push_back(cyc);
      end
    end
    if (rst_n && ov8 && ordy8) begin
      if (q8.size() == 0) check("unexpected_out8", 1, 0);
      else begin
        m8 = q8.pop_front();
        check("sb_state8", os8, m8.st);
        check("sb_tag8", ot8, m8.tag);
      end
    end
  end

  task automatic send4(input logic [127:0] s, input bit inv, input logic [3:0] tag);
    bit acc = 1'b0;
    v4 = 1'b1; st4 = s; inv4 = inv; tg4 = tag;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (r4) begin
        q4.push_back(exp_t'{ref_shift({128'b0, s}, 4, inv), tag});
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    v4 = 1'b0;
    if (!acc) check("send4_timeout", 0, 1);
  endtask

  task automatic send8(input logic [255:0] s, input bit inv, input logic [3:0] tag);
    bit acc = 1'b0;
    v8 = 1'b1; st8 = s; inv8 = inv; tg8 = tag;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (r8) begin
        q8.push_back(exp_t'{ref_shift(s, 8, inv), tag});
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    v8 = 1'b0;
    if (!acc) check("send8_timeout", 0, 1);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 100; n++) begin
      if (q4.size() == 0 && q8.size() == 0 && !busy4 && !busy8) break;
      @(posedge clk); #1;
    end
    check(tag, (q4.size() == 0 && q8.size() == 0 && !busy4 && !busy8), 1);
  endtask

  initial begin
    logic [127:0] kat_in, kat_out, a_blk, b_blk;
    logic [255:0] bytes8, res8;
    int base, b_acc;
    bit exp_r;

    v4 = 0; inv4 = 0; st4 = '0; tg4 = '0; ordy4 = 1;
    v8 = 0; inv8 = 0; st8 = '0; tg8 = '0; ordy8 = 1;
    kat_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
    kat_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", ov4, 0);
    check("rst_out_state", os4, 0);
    check("rst_out_tag", ot4, 0);
    check("rst_busy", busy4, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", r4, 1);

    // Known-answer vectors, both directions.
    send4(kat_in, 1'b0, 4'd5);
    check("kat_fwd_valid", ov4, 1);
    check("kat_fwd_state", os4, kat_out);
    check("kat_fwd_tag", ot4, 5);
    send4(kat_out, 1'b1, 4'd6);
    check("kat_inv_state", os4, kat_in);
    drain("drain_kat");

    // NB=8: ascending bytes forward, then inverse of the result.
    for (int i = 0; i < 32; i++) bytes8[255-8*i -: 8] = 8'(i);
    send8(bytes8, 1'b0, 4'd3);
    res8 = os8;
    check("nb8_col0", res8[255:224], 32'h00050e13);
    send8(res8, 1'b1, 4'd4);
    check("nb8_roundtrip", os8, bytes8);
    drain("drain_nb8");

    // Back-to-back stream with alternating mode.
    base = pop_cyc.size();
    for (int t = 0; t < 16; t++)
      send4({$urandom, $urandom, $urandom, $urandom}, t[0], 4'(t));
    drain("drain_b2b");
    check("b2b_count", pop_cyc.size() - base, 16);
    if (pop_cyc.size() - base == 16)
      check("b2b_span", pop_cyc[base+15] - pop_cyc[base], 15);

    // Backpressure: hold out_ready low with one block pending and a second offered.
    a_blk = {$urandom, $urandom, $urandom, $urandom};
    b_blk = {$urandom, $urandom, $urandom, $urandom};
    ordy4 = 0;
    send4(a_blk, 1'b0, 4'd10);
    v4 = 1; st4 = b_blk; inv4 = 1; tg4 = 4'd11;
    b_acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_r = SKID && (i == 0);
      check("stall_valid", ov4, 1);
      check("stall_state", os4, ref_shift({128'b0, a_blk}, 4, 1'b0));
      check("stall_ready", r4, exp_r);
      if (v4 && r4) begin
        q4.push_back(exp_t'{ref_shift({128'b0, b_blk}, 4, 1'b1), 4'd11});
        b_acc++;
      end
      @(posedge clk); #1;
      if (b_acc != 0) v4 = 0;
    end
    check("stall_accepts", b_acc, SKID ? 1 : 0);
    ordy4 = 1;
    if (b_acc == 0) send4(b_blk, 1'b1, 4'd11);
    drain("drain_stall");

    // Asynchronous reset while a block is held on the output.
    ordy4 = 0;
    send4(kat_in, 1'b0, 4'd7);
    check("pre_rst_valid", ov4, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", ov4, 0);
    check("arst_out_state", os4, 0);
    check("arst_out_tag", ot4, 0);
    check("arst_busy", busy4, 0);
    q4.delete();
    ordy4 = 1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_arst", r4, 1);
    send4(kat_out, 1'b1, 4'd9);
    check("post_rst_state", os4, kat_in);
    check("post_rst_tag", ot4, 9);
    drain("drain_post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
